// File: rtl/fa_hw_checker.sv
// Exhaustive stimulus generator and response checker for a 1-bit full adder.
// Steps {a,b,c} through 000..111, samples s/cout after a settle delay, and reports the results.
module fa_hw_checker #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       s,
  input  logic       cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] abc_q, abc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic [2:0] fail_vec_q, fail_vec_d;

  logic exp_s, exp_cout, mismatch;

  // Golden full-adder response for the vector currently driven.
  assign exp_s    = abc_q[2] ^ abc_q[1] ^ abc_q[0];
  assign exp_cout = (abc_q[2] & abc_q[1]) | (abc_q[2] & abc_q[0]) | (abc_q[1] & abc_q[0]);
  assign mismatch = (s != exp_s) || (cout != exp_cout);

  always_comb begin
    // NOTE: every *_d gets a hold default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    abc_d      = abc_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    fail_vec_d = fail_vec_q;

    unique case (state_q)
      IDLE, DONE: begin
        // A start request while busy never reaches here, so it is ignored.
        if (start) begin
          vec_d      = 3'd0;
          abc_d      = 3'd0;
          cnt_d      = CNT_RELOAD;
          err_cnt_d  = 4'd0;
          fail_vec_d = 3'd0;
          pass_d     = 1'b0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      CHECK: begin
        if (mismatch) begin
          err_cnt_d = err_cnt_q + 4'd1;
          if (err_cnt_q == 4'd0) begin
            fail_vec_d = abc_q;
          end
        end
        if (vec_q != 3'd7) begin
          vec_d   = vec_q + 3'd1;
          abc_d   = vec_q + 3'd1;
          cnt_d   = CNT_RELOAD;
          state_d = SETTLE;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == 4'd0);
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= 3'd0;
      cnt_q      <= 8'd0;
      abc_q      <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= 4'd0;
      fail_vec_q <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      abc_q      <= abc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  assign a        = abc_q[2];
  assign b        = abc_q[1];
  assign c        = abc_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_fa_hw_checker.sv
// Self-checking bench: a faultable adder model drives two checkers (settle 4 and 1);
// expected results come from per-vector fault masks.
module tb_fa_hw_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, start1;
  logic [7:0] s_mask, c_mask;   // bit v set => adder output is wrong for vector v

  logic       a, b, c, s, cout, busy, done, pass;
  logic [3:0] err_cnt;
  logic [2:0] fail_vec;
  logic       a1, b1, c1, s1, cout1, busy1, done1, pass1;
  logic [3:0] err_cnt1;
  logic [2:0] fail_vec1;

  logic [1:0] sum0, sum1;
  assign sum0 = 2'(a)  + 2'(b)  + 2'(c);
  assign sum1 = 2'(a1) + 2'(b1) + 2'(c1);
  assign s     = sum0[0] ^ s_mask[{a, b, c}];
  assign cout  = sum0[1] ^ c_mask[{a, b, c}];
  assign s1    = sum1[0] ^ s_mask[{a1, b1, c1}];
  assign cout1 = sum1[1] ^ c_mask[{a1, b1, c1}];

  fa_hw_checker #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c), .s(s), .cout(cout),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_vec(fail_vec)
  );

  fa_hw_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c(c1), .s(s1), .cout(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1), .fail_vec(fail_vec1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: count faulty vectors and locate the lowest one.
  task automatic ref_result(output int exp_err, output logic [2:0] exp_first);
    exp_err   = 0;
    exp_first = 3'd0;
    for (int v = 7; v >= 0; v--) begin
      if (s_mask[v] || c_mask[v]) begin
        exp_err++;
        exp_first = 3'(v);
      end
    end
  endtask

  task automatic run_main(input int extra_start_at, input int reset_at);
    int exp_err, seq_bad, hold_bad, lat;
    logic [2:0] exp_first;
    ref_result(exp_err, exp_first);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("acc_busy", busy, 1);
    check("acc_clear", {done, pass, err_cnt, fail_vec}, 0);
    check("acc_abc", {a, b, c}, 0);
    seq_bad = 0;
    lat     = 0;
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      if (k == extra_start_at) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (k == reset_at) begin
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_outputs", {a, b, c, busy, done, pass, err_cnt, fail_vec}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_idle", {busy, done, a, b, c}, 0);
        return;
      end
      if (done) lat = k;
      else begin
        if (!busy) seq_bad++;
        if ({a, b, c} != 3'(k / 5)) seq_bad++;
      end
    end
    check("latency", lat, 40);
    check("sequence", seq_bad, 0);
    check("end_busy", busy, 0);
    check("end_abc", {a, b, c}, 7);
    check("err_cnt", err_cnt, exp_err);
    check("fail_vec", fail_vec, exp_first);
    check("pass", pass, exp_err == 0);
    hold_bad = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (!done || busy || {a, b, c} != 3'd7 || err_cnt != 4'(exp_err) ||
          fail_vec != exp_first || pass != (exp_err == 0)) hold_bad++;
    end
    check("done_hold", hold_bad, 0);
  endtask

  task automatic run_s1();
    int exp_err, seq_bad, lat;
    logic [2:0] exp_first;
    ref_result(exp_err, exp_first);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    check("s1_acc", {busy1, done1, a1, b1, c1}, 5'b10000);
    seq_bad = 0;
    lat     = 0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (done1) lat = k;
      else if (!busy1 || {a1, b1, c1} != 3'(k / 2)) seq_bad++;
    end
    check("s1_latency", lat, 16);
    check("s1_sequence", seq_bad, 0);
    check("s1_err_cnt", err_cnt1, exp_err);
    check("s1_fail_vec", fail_vec1, exp_first);
    check("s1_pass", pass1, exp_err == 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    s_mask = 8'h00;
    c_mask = 8'h00;
    #23;
    check("reset_out", {a, b, c, busy, done, pass, err_cnt, fail_vec}, 0);
    check("reset_out1", {a1, b1, c1, busy1, done1, pass1, err_cnt1, fail_vec1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_main(0, 0);                              // correct adder

    for (int v = 0; v < 8; v++)                  // cout stuck-at-0
      c_mask[v] = ($countones(3'(v)) >= 2);
    run_main(0, 0);

    s_mask = 8'hFF;                              // s inverted, restarted from DONE
    c_mask = 8'h00;
    run_main(0, 0);

    s_mask = 8'h00;
    run_main(10, 0);                             // second start mid-run ignored
    run_main(0, 20);                             // reset aborts run
    run_main(0, 0);

    for (int i = 0; i < 6; i++) begin
      s_mask = 8'($urandom);
      c_mask = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        s_mask = 8'h00;
        c_mask = 8'h00;
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_main(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 39)) : 0, 0);
    end

    s_mask = 8'h00;
    c_mask = 8'h00;
    run_s1();
    for (int v = 0; v < 8; v++)
      c_mask[v] = ($countones(3'(v)) >= 2);
    run_s1();
    s_mask = 8'($urandom);
    c_mask = 8'($urandom);
    run_s1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
